// File: rtl/jalu_sequencer_if.sv
// Command handshake bundle for jalu_sequencer: the issuer drives a command and valid,
// and the sequencer answers with ready.
interface jalu_sequencer_if;
  logic       wcmd_valid;
  logic       wcmd_ready;
  logic [2:0] bcmd_op;
  logic [1:0] bcmd_ra;
  logic [1:0] bcmd_rb;
  logic [7:0] bimm;

  modport master (
    output wcmd_valid, bcmd_op, bcmd_ra, bcmd_rb, bimm,
    input  wcmd_ready
  );

  modport slave (
    input  wcmd_valid, bcmd_op, bcmd_ra, bcmd_rb, bimm,
    output wcmd_ready
  );
endinterface

// File: rtl/jalu_sequencer.sv
// Four-state sequencer that feeds an external 8-bit ALU from a 4x8 register file.
// Optional macro JALU_SEQ_CARRY_CHAIN_EN routes the latched C flag to the ALU carry-in.
module jalu_sequencer (
  input  logic            wclk,
  input  logic            wrst_n,
  jalu_sequencer_if.slave cmd,
  output logic [7:0]      bas,
  output logic [7:0]      bbs,
  output logic            wci,
  output logic [2:0]      bops,
  input  logic [7:0]      bcs,
  input  logic            wco,
  input  logic            walo,
  input  logic            weqo,
  input  logic            wz,
  output logic            wdone,
  output logic [7:0]      bresult,
  output logic [3:0]      bflags,
  input  logic [1:0]      brd_addr,
  output logic [7:0]      brd_data
);

  typedef enum logic [1:0] {IDLE, LOADB, EXEC, WB} state_e;

  localparam logic [2:0] OP_CMP  = 3'd6;
  localparam logic [2:0] OP_LDI  = 3'd7;
  localparam logic [2:0] OP_NONE = 3'b111;

  state_e     state_q, state_d;
  logic [2:0] op_q, op_d;
  logic [1:0] ra_q, ra_d;
  logic [1:0] rb_q, rb_d;
  logic [7:0] tmp_q, tmp_d;
  logic [7:0] acc_q, acc_d;
  logic [3:0] flags_q, flags_d;
  logic [7:0] regs_q [4];
  logic [7:0] regs_d [4];
  logic       carry_in;

`ifdef JALU_SEQ_CARRY_CHAIN_EN
  assign carry_in = flags_q[3];
`else
  assign carry_in = 1'b0;
`endif

  assign cmd.wcmd_ready = (state_q == IDLE);
  assign bresult        = acc_q;
  assign bflags         = flags_q;
  assign brd_data       = regs_q[brd_addr];

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    ra_d    = ra_q;
    rb_d    = rb_q;
    tmp_d   = tmp_q;
    acc_d   = acc_q;
    flags_d = flags_q;
    regs_d  = regs_q;
    bas     = 8'h00;
    bbs     = 8'h00;
    wci     = 1'b0;
    bops    = OP_NONE;
    wdone   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (cmd.wcmd_valid) begin
          op_d = cmd.bcmd_op;
          ra_d = cmd.bcmd_ra;
          rb_d = cmd.bcmd_rb;
          // Load-immediate bypasses the ALU entirely and leaves the flags alone.
          if (cmd.bcmd_op == OP_LDI) begin
            acc_d   = cmd.bimm;
            state_d = WB;
          end else begin
            state_d = LOADB;
          end
        end
      end
      LOADB: begin
        tmp_d   = regs_q[rb_q];
        state_d = EXEC;
      end
      EXEC: begin
        bas     = regs_q[ra_q];
        bbs     = tmp_q;
        wci     = carry_in;
        bops    = op_q;
        acc_d   = bcs;
        flags_d = {wco, walo, weqo, wz};
        state_d = WB;
      end
      WB: begin
        wdone = 1'b1;
        if (op_q != OP_CMP) begin
          regs_d[rb_q] = acc_q;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      state_q <= IDLE;
      op_q    <= '0;
      ra_q    <= '0;
      rb_q    <= '0;
      tmp_q   <= '0;
      acc_q   <= '0;
      flags_q <= '0;
      for (int i = 0; i < 4; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      ra_q    <= ra_d;
      rb_q    <= rb_d;
      tmp_q   <= tmp_d;
      acc_q   <= acc_d;
      flags_q <= flags_d;
      regs_q  <= regs_d;
    end
  end

endmodule

// File: tb/tb_jalu_sequencer.sv
// Self-checking bench for jalu_sequencer: directed vector table, back-to-back and
// reset-abort sequences, then randomized commands against a register/flag model.
module tb_jalu_sequencer;

  logic       wclk;
  logic       wrst_n;
  logic [7:0] bas, bbs, bcs;
  logic       wci, wco, walo, weqo, wz;
  logic [2:0] bops;
  logic       wdone;
  logic [7:0] bresult;
  logic [3:0] bflags;
  logic [1:0] brd_addr;
  logic [7:0] brd_data;
  logic [11:0] alu_out;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [7:0] m_regs [4];
  logic [3:0] m_flags;

  typedef struct {
    logic [2:0] op;
    logic [1:0] ra;
    logic [1:0] rb;
    logic [7:0] imm;
    logic [7:0] exp_res;
    logic [3:0] exp_flags;
    int         exp_lat;
    logic [7:0] exp_rb;
  } vec_t;

  vec_t tbl [12];

  jalu_sequencer_if cmd_if ();

  jalu_sequencer dut (
    .wclk     (wclk),
    .wrst_n   (wrst_n),
    .cmd      (cmd_if),
    .bas      (bas),
    .bbs      (bbs),
    .wci      (wci),
    .bops     (bops),
    .bcs      (bcs),
    .wco      (wco),
    .walo     (walo),
    .weqo     (weqo),
    .wz       (wz),
    .wdone    (wdone),
    .bresult  (bresult),
    .bflags   (bflags),
    .brd_addr (brd_addr),
    .brd_data (brd_data)
  );

  initial wclk = 1'b0;
  always #5 wclk = ~wclk;
  always @(posedge wclk) cyc <= cyc + 1;

  // Behavioural ALU: returns {carry, a_larger, equal, zero, result}.
  function automatic logic [11:0] alu_f(input logic [2:0] op, input logic [7:0] a,
                                        input logic [7:0] b, input logic ci);
    logic [8:0] s;
    logic [7:0] r;
    logic       co;
    s  = {1'b0, a} + {1'b0, b} + {8'd0, ci};
    r  = 8'h00;
    co = 1'b0;
    case (op)
      3'd0: begin r = s[7:0]; co = s[8]; end
      3'd1: begin r = {ci, a[7:1]}; co = a[0]; end
      3'd2: begin r = {a[6:0], ci}; co = a[7]; end
      3'd3: r = ~a;
      3'd4: r = a & b;
      3'd5: r = a | b;
      3'd6: begin r = s[7:0]; co = s[8]; end
      default: r = 8'h00;
    endcase
    return {co, (a > b), (a == b), (r == 8'h00), r};
  endfunction

  always_comb alu_out = alu_f(bops, bas, bbs, wci);
  assign bcs  = alu_out[7:0];
  assign wz   = alu_out[8];
  assign weqo = alu_out[9];
  assign walo = alu_out[10];
  assign wco  = alu_out[11];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %0h want %0h", name, got, exp);
    end
  endtask

  // Reference: what one command does to the register file, flags and result.
  task automatic ref_step(input logic [2:0] op, input logic [1:0] ra, input logic [1:0] rb,
                          input logic [7:0] imm, output logic [7:0] res, output int lat);
    logic [11:0] r;
    logic        ci;
    if (op == 3'd7) begin
      res = imm;
      m_regs[rb] = imm;
      lat = 1;
    end else begin
`ifdef JALU_SEQ_CARRY_CHAIN_EN
      ci = m_flags[3];
`else
      ci = 1'b0;
`endif
      r = alu_f(op, m_regs[ra], m_regs[rb], ci);
      res = r[7:0];
      m_flags = r[11:8];
      if (op != 3'd6) m_regs[rb] = res;
      lat = 3;
    end
  endtask

  task automatic apply_stimulus(input logic [2:0] op, input logic [1:0] ra, input logic [1:0] rb,
                                input logic [7:0] imm, output int lat,
                                output logic [7:0] res, output logic [3:0] flg);
    int n;
    @(negedge wclk);
    cmd_if.bcmd_op    = op;
    cmd_if.bcmd_ra    = ra;
    cmd_if.bcmd_rb    = rb;
    cmd_if.bimm       = imm;
    cmd_if.wcmd_valid = 1'b1;
    n = 0;
    while (!cmd_if.wcmd_ready && n < 20) begin
      @(negedge wclk);
      n++;
    end
    check("ready_wait", 32'(cmd_if.wcmd_ready), 32'd1);
    @(posedge wclk);
    #1 cmd_if.wcmd_valid = 1'b0;
    lat = 0;
    while (lat < 10) begin
      @(negedge wclk);
      lat++;
      if (wdone) break;
    end
    res = bresult;
    flg = bflags;
  endtask

  // Called at the negedge where wdone was seen; checks the idle cycle that follows.
  task automatic check_output();
    @(negedge wclk);
    check("wdone_pulse", 32'(wdone), 32'd0);
    check("idle_ready", 32'(cmd_if.wcmd_ready), 32'd1);
    check("idle_bops", 32'(bops), 32'd7);
    check("idle_bas_bbs", {16'd0, bas, bbs}, 32'd0);
    check("idle_wci", 32'(wci), 32'd0);
    check("flags_model", 32'(bflags), 32'(m_flags));
    for (int i = 0; i < 4; i++) begin
      brd_addr = 2'(i);
      #1 check($sformatf("reg%0d", i), 32'(brd_data), 32'(m_regs[i]));
    end
  endtask

  task automatic run_checked(input logic [2:0] op, input logic [1:0] ra, input logic [1:0] rb,
                             input logic [7:0] imm);
    logic [7:0] exp_res, res;
    logic [3:0] flg;
    int         exp_lat, lat;
    ref_step(op, ra, rb, imm, exp_res, exp_lat);
    apply_stimulus(op, ra, rb, imm, lat, res, flg);
    check($sformatf("lat_op%0d", op), 32'(lat), 32'(exp_lat));
    check($sformatf("res_op%0d", op), 32'(res), 32'(exp_res));
    check($sformatf("flags_op%0d", op), 32'(flg), 32'(m_flags));
    check_output();
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [7:0] r1, r2, res;
    logic [3:0] flg;
    int         l1, l2, lat, low, t1, t2, seen1;
    logic [7:0] obs1;

    // load r0/r1, add, load r2/r3, carry-chained add, cmp, shl, shr
    tbl[0]  = '{3'd7, 2'd0, 2'd0, 8'h0F, 8'h0F, 4'b0000, 1, 8'h0F};
    tbl[1]  = '{3'd7, 2'd0, 2'd1, 8'hF1, 8'hF1, 4'b0000, 1, 8'hF1};
    tbl[2]  = '{3'd0, 2'd0, 2'd1, 8'h00, 8'h00, 4'b1001, 3, 8'h00};
    tbl[3]  = '{3'd7, 2'd0, 2'd2, 8'h01, 8'h01, 4'b1001, 1, 8'h01};
    tbl[4]  = '{3'd7, 2'd0, 2'd3, 8'h01, 8'h01, 4'b1001, 1, 8'h01};
`ifdef JALU_SEQ_CARRY_CHAIN_EN
    tbl[5]  = '{3'd0, 2'd2, 2'd3, 8'h00, 8'h03, 4'b0010, 3, 8'h03};
`else
    tbl[5]  = '{3'd0, 2'd2, 2'd3, 8'h00, 8'h02, 4'b0010, 3, 8'h02};
`endif
    tbl[6]  = '{3'd7, 2'd0, 2'd0, 8'h20, 8'h20, 4'b0010, 1, 8'h20};
    tbl[7]  = '{3'd7, 2'd0, 2'd1, 8'h10, 8'h10, 4'b0010, 1, 8'h10};
    tbl[8]  = '{3'd6, 2'd0, 2'd1, 8'h00, 8'h30, 4'b0100, 3, 8'h10};
    tbl[9]  = '{3'd7, 2'd0, 2'd0, 8'h81, 8'h81, 4'b0100, 1, 8'h81};
    tbl[10] = '{3'd2, 2'd0, 2'd1, 8'h00, 8'h02, 4'b1100, 3, 8'h02};
`ifdef JALU_SEQ_CARRY_CHAIN_EN
    tbl[11] = '{3'd1, 2'd0, 2'd2, 8'h00, 8'hC0, 4'b1100, 3, 8'hC0};
`else
    tbl[11] = '{3'd1, 2'd0, 2'd2, 8'h00, 8'h40, 4'b1100, 3, 8'h40};
`endif

    for (int i = 0; i < 4; i++) m_regs[i] = 8'h00;
    m_flags = 4'h0;
    cmd_if.wcmd_valid = 1'b0;
    cmd_if.bcmd_op    = 3'd0;
    cmd_if.bcmd_ra    = 2'd0;
    cmd_if.bcmd_rb    = 2'd0;
    cmd_if.bimm       = 8'h00;
    brd_addr = 2'd0;
    wrst_n   = 1'b0;

    #12;
    check("rst_ready", 32'(cmd_if.wcmd_ready), 32'd1);
    check("rst_wdone", 32'(wdone), 32'd0);
    check("rst_bops", 32'(bops), 32'd7);
    check("rst_flags", 32'(bflags), 32'd0);
    check("rst_result", 32'(bresult), 32'd0);
    for (int i = 0; i < 4; i++) begin
      brd_addr = 2'(i);
      #1 check($sformatf("rst_reg%0d", i), 32'(brd_data), 32'd0);
    end
    @(negedge wclk);
    wrst_n = 1'b1;

    $display("[TB] directed vector table");
    for (int i = 0; i < 12; i++) begin
      ref_step(tbl[i].op, tbl[i].ra, tbl[i].rb, tbl[i].imm, res, l1);
      apply_stimulus(tbl[i].op, tbl[i].ra, tbl[i].rb, tbl[i].imm, lat, res, flg);
      check($sformatf("vec%0d_lat", i), 32'(lat), 32'(tbl[i].exp_lat));
      check($sformatf("vec%0d_res", i), 32'(res), 32'(tbl[i].exp_res));
      check($sformatf("vec%0d_flags", i), 32'(flg), 32'(tbl[i].exp_flags));
      check_output();
      brd_addr = tbl[i].rb;
      #1 check($sformatf("vec%0d_rb", i), 32'(brd_data), 32'(tbl[i].exp_rb));
    end

    $display("[TB] back-to-back commands with valid held high");
    ref_step(3'd0, 2'd2, 2'd3, 8'h00, r1, l1);
    ref_step(3'd5, 2'd0, 2'd2, 8'h00, r2, l2);
    @(negedge wclk);
    cmd_if.bcmd_op = 3'd0; cmd_if.bcmd_ra = 2'd2; cmd_if.bcmd_rb = 2'd3;
    cmd_if.wcmd_valid = 1'b1;
    check("b2b_ready0", 32'(cmd_if.wcmd_ready), 32'd1);
    @(posedge wclk);
    #1 t1 = cyc;
    @(negedge wclk);
    cmd_if.bcmd_op = 3'd5; cmd_if.bcmd_ra = 2'd0; cmd_if.bcmd_rb = 2'd2;
    low = 0; seen1 = 0; obs1 = 8'h00;
    while (!cmd_if.wcmd_ready && low < 10) begin
      low++;
      if (wdone) begin seen1 = 1; obs1 = bresult; end
      @(negedge wclk);
    end
    check("b2b_ready_low", 32'(low), 32'd3);
    check("b2b_done1", 32'(seen1), 32'd1);
    check("b2b_res1", 32'(obs1), 32'(r1));
    @(posedge wclk);
    #1 t2 = cyc;
    cmd_if.wcmd_valid = 1'b0;
    check("b2b_spacing", 32'(t2 - t1), 32'd4);
    lat = 0;
    while (lat < 10) begin
      @(negedge wclk);
      lat++;
      if (wdone) break;
    end
    check("b2b_lat2", 32'(lat), 32'd3);
    check("b2b_res2", 32'(bresult), 32'(r2));
    check_output();

    $display("[TB] randomized commands");
    for (int i = 0; i < 60; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge wclk);
      run_checked(3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
                  2'($urandom_range(0, 3)), 8'($urandom));
    end

    $display("[TB] reset during EXEC");
    @(negedge wclk);
    cmd_if.bcmd_op = 3'd0; cmd_if.bcmd_ra = 2'd0; cmd_if.bcmd_rb = 2'd1;
    cmd_if.wcmd_valid = 1'b1;
    @(posedge wclk);
    #1 cmd_if.wcmd_valid = 1'b0;
    @(posedge wclk);
    #2 wrst_n = 1'b0;
    #1 check("abort_rst_ready", 32'(cmd_if.wcmd_ready), 32'd1);
    check("abort_rst_bops", 32'(bops), 32'd7);
    repeat (2) begin
      @(negedge wclk);
      check("abort_rst_wdone", 32'(wdone), 32'd0);
    end
    @(negedge wclk);
    wrst_n = 1'b1;
    for (int i = 0; i < 4; i++) m_regs[i] = 8'h00;
    m_flags = 4'h0;
    @(posedge wclk);
    #1 check("abort_ready", 32'(cmd_if.wcmd_ready), 32'd1);
    check("abort_wdone", 32'(wdone), 32'd0);
    check("abort_flags", 32'(bflags), 32'd0);
    check("abort_result", 32'(bresult), 32'd0);
    for (int i = 0; i < 4; i++) begin
      brd_addr = 2'(i);
      #1 check($sformatf("abort_reg%0d", i), 32'(brd_data), 32'd0);
    end
    repeat (4) begin
      @(negedge wclk);
      check("abort_no_done", 32'(wdone), 32'd0);
    end

    for (int i = 0; i < 10; i++) begin
      run_checked(3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
                  2'($urandom_range(0, 3)), 8'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/jalu_sequencer.md
JALU_SEQUENCER -- requirements
Module: jalu_sequencer

Interface
REQ-001 Parameters: none; datapath fixed at 8 bits; register file fixed at 4 x 8 bits.
REQ-002 wclk  in  1  single clock; all state updates on rising edge.
REQ-003 wrst_n  in  1  reset, asynchronous, active-low.
REQ-004 wcmd_valid  in  1  command offered.
REQ-005 wcmd_ready  out  1  sequencer can accept a command; high only in IDLE.
REQ-006 bcmd_op  in  3  0 add, 1 shr, 2 shl, 3 not, 4 and, 5 or, 6 cmp, 7 load-immediate.
REQ-007 bcmd_ra  in  2  source register, drives ALU A.
REQ-008 bcmd_rb  in  2  second source, driving ALU B, and destination register.
REQ-009 bimm  in  8  immediate for op 7.
REQ-010 bas, bbs  out  8 each  ALU operands.
REQ-011 wci  out  1  ALU carry-in.
REQ-012 bops  out  3  ALU op select.
REQ-013 bcs  in  8  ALU result.
REQ-014 wco, walo, weqo, wz  in  1 each  ALU carry, A-larger, equal and zero flags.
REQ-015 wdone  out  1  one-cycle completion pulse.
REQ-016 bresult  out  8  value written back (ACC); valid while wdone.
REQ-017 bflags  out  4  latched flags: [3] C, [2] A, [1] E, [0] Z.
REQ-018 brd_addr  in  2; brd_data  out  8  combinational register-file read.

Function
REQ-019 FSM states: IDLE, LOADB, EXEC, WB.
REQ-020 In IDLE, wcmd_valid && wcmd_ready SHALL accept the command and latch op/ra/rb.
REQ-021 Accepting ops 0-6 SHALL go IDLE->LOADB; accepting op 7 SHALL go IDLE->WB with ACC<=bimm.
REQ-022 LOADB SHALL capture TMP<=reg[rb] and go to EXEC.
REQ-023 EXEC SHALL drive bas=reg[ra], bbs=TMP, bops=op, then capture ACC<=bcs and {C,A,E,Z}<={wco,walo,weqo,wz}, then go to WB.
REQ-024 Outside EXEC, bops SHALL be 3'b111 so no ALU result is enabled (bcs=0), and bas/bbs SHALL be 0.
REQ-025 WB SHALL assert wdone; the edge leaving WB SHALL write reg[rb]<=ACC, except op 6, which writes nothing; next state IDLE.
REQ-026 Op 7 SHALL leave bflags unchanged; ops 0-6 SHALL update all four flags.
REQ-027 Latency from the accept edge to wdone high: 3 cycles for ops 0-6, 1 cycle for op 7.
REQ-028 Throughput: one command per 4 cycles for ops 0-6, one per 2 cycles for op 7; commands offered while busy SHALL be held off, never dropped.
REQ-029 ra==rb SHALL be legal: both operands are the pre-operation value.
REQ-030 Writes to the register read by brd_addr SHALL be visible on brd_data after the WB exit edge.

Reset
REQ-031 While wrst_n=0: state IDLE, registers/TMP/ACC/flags/latched command all 0, wdone=0, wcmd_ready=1, bops=3'b111.
REQ-032 Reset during LOADB/EXEC/WB SHALL abort the command with no write-back and no wdone pulse.

Configuration
REQ-033 Macro JALU_SEQ_CARRY_CHAIN_EN: when defined, wci SHALL equal the latched C flag during EXEC, allowing multi-byte add/shift chains; when undefined, wci SHALL be constant 0.

Verification
REQ-034 load r0=0x0F, load r1=0xF1, add ra=0 rb=1 -> wdone 3 cycles after accept, r1=0x00, bflags=C1 A0 E0 Z1.
REQ-035 After REQ-034, load r2=0x01, load r3=0x01, add ra=2 rb=3 -> r3=0x03 with macro defined, 0x02 without; C=0 in both cases.
REQ-036 r0=0x20, r1=0x10, cmp ra=0 rb=1 -> A=1, E=0, r1 stays 0x10, bresult=0x30.
REQ-037 r0=0x81, C=0, shl ra=0 rb=1 -> r1=0x02, C=1; then shr ra=0 rb=2 with macro defined -> r2=0xC0, C=1.
REQ-038 wcmd_valid held high across two back-to-back commands -> wcmd_ready low for 3 cycles after each accept; second command accepted exactly 4 cycles after the first; both write back.
REQ-039 Pull wrst_n low during EXEC of add r1 -> no wdone, all registers 0, wcmd_ready=1 in the first cycle after release.
